// File: rtl/vx_commit_pkg.sv
// Shared types and constants for the commit/writeback return path.
package vx_commit_pkg;

    localparam int DEF_NUM_THREADS = 4;
    localparam int DEF_NW_BITS     = 2;
    localparam int DEF_UUID_BITS   = 44;
    localparam int DEF_NR_BITS     = 6;

    localparam int UNIT_ALU = 0;
    localparam int UNIT_LSU = 1;
    localparam int UNIT_CSR = 2;
    localparam int UNIT_FPU = 3;
    localparam int UNIT_GPU = 4;

    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic [DEF_UUID_BITS-1:0]      uuid;
        logic [DEF_NW_BITS-1:0]        wid;
        logic [DEF_NUM_THREADS-1:0]    tmask;
        logic [31:0]                   PC;
        logic [DEF_NR_BITS-1:0]        rd;
        logic                          wb;
        logic                          eop;
        logic [DEF_NUM_THREADS*32-1:0] data;
    } commit_t;

    // Only wb=1 commits are queued, so the queued form drops the wb flag.
    typedef struct packed {
        logic [DEF_UUID_BITS-1:0]      uuid;
        logic [DEF_NW_BITS-1:0]        wid;
        logic [DEF_NUM_THREADS-1:0]    tmask;
        logic [31:0]                   PC;
        logic [DEF_NR_BITS-1:0]        rd;
        logic                          eop;
        logic [DEF_NUM_THREADS*32-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves past the winner only when the grant is accepted.
module vx_rr_arbiter #(
    parameter int N = 5,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  i_req,
    input  logic          i_advance,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx
);

    logic [IW-1:0] r_ptr;
    logic          w_found;

    always_comb begin
        w_found     = 1'b0;
        o_grant_idx = r_ptr;
        o_grant     = '0;
        for (int k = 0; k < N; k++) begin
            int cand;
            cand = int'(r_ptr) + k;
            if (cand >= N) cand = cand - N;
            if (!w_found && i_req[cand]) begin
                w_found     = 1'b1;
                o_grant_idx = IW'(cand);
            end
        end
        if (w_found) o_grant = N'(1) << o_grant_idx;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_grant_idx == IW'(N - 1)) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/vx_commit_arbiter.sv
// Collects unit commits round-robin into a 2-entry writeback FIFO and
// counts retired instructions (eop packets), including wb=0 commits.
module vx_commit_arbiter
    import vx_commit_pkg::*;
#(
    parameter int NUM_UNITS   = 5,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int UUID_BITS   = 44,
    parameter int NR_BITS     = 6,
    parameter int CNT_WIDTH   = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_UNITS-1:0]                cmt_valid,
    output logic [NUM_UNITS-1:0]                cmt_ready,
    input  logic [NUM_UNITS*UUID_BITS-1:0]      cmt_uuid,
    input  logic [NUM_UNITS*NW_BITS-1:0]        cmt_wid,
    input  logic [NUM_UNITS*NUM_THREADS-1:0]    cmt_tmask,
    input  logic [NUM_UNITS*32-1:0]             cmt_PC,
    input  logic [NUM_UNITS*NR_BITS-1:0]        cmt_rd,
    input  logic [NUM_UNITS-1:0]                cmt_wb,
    input  logic [NUM_UNITS-1:0]                cmt_eop,
    input  logic [NUM_UNITS*NUM_THREADS*32-1:0] cmt_data,
    output logic                                wb_valid,
    input  logic                                wb_ready,
    output logic [UUID_BITS-1:0]                wb_uuid,
    output logic [NW_BITS-1:0]                  wb_wid,
    output logic [NUM_THREADS-1:0]              wb_tmask,
    output logic [31:0]                         wb_PC,
    output logic [NR_BITS-1:0]                  wb_rd,
    output logic                                wb_eop,
    output logic [NUM_THREADS*32-1:0]           wb_data,
    output logic [CNT_WIDTH-1:0]                instret
);

    localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int DW = NUM_THREADS * 32;

    commit_t        w_units [NUM_UNITS];
    commit_t        w_sel;
    wb_entry_t      r_mem [FIFO_DEPTH];
    wb_entry_t      w_head;
    wb_entry_t      w_push_entry;
    logic [1:0]     r_count;
    logic           r_head;
    logic           w_tail;
    logic [CNT_WIDTH-1:0] r_instret;
    logic [NUM_UNITS-1:0] w_grant;
    logic [IW-1:0]  w_grant_idx;
    logic           w_ok;
    logic           w_accept;
    logic           w_push;
    logic           w_pop;

    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unpack
            assign w_units[gi] = commit_t'({
                cmt_uuid [gi*UUID_BITS   +: UUID_BITS],
                cmt_wid  [gi*NW_BITS     +: NW_BITS],
                cmt_tmask[gi*NUM_THREADS +: NUM_THREADS],
                cmt_PC   [gi*32          +: 32],
                cmt_rd   [gi*NR_BITS     +: NR_BITS],
                cmt_wb   [gi],
                cmt_eop  [gi],
                cmt_data [gi*DW          +: DW]
            });
        end
    endgenerate

    vx_rr_arbiter #(.N(NUM_UNITS)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_req       (cmt_valid),
        .i_advance   (w_accept),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign w_sel = w_units[w_grant_idx];

    // Silent (wb=0) retirements bypass the FIFO, so only wb=1 needs space.
    assign w_ok      = reset && (!w_sel.wb || (r_count != 2'(FIFO_DEPTH)));
    assign cmt_ready = w_grant & {NUM_UNITS{w_ok}};
    assign w_accept  = |(cmt_valid & cmt_ready);
    assign w_push    = w_accept && w_sel.wb;
    assign w_pop     = wb_valid && wb_ready;
    assign w_tail    = r_head ^ r_count[0];

    assign w_push_entry = '{uuid: w_sel.uuid, wid: w_sel.wid, tmask: w_sel.tmask,
                            PC: w_sel.PC, rd: w_sel.rd, eop: w_sel.eop, data: w_sel.data};

    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_tail] <= w_push_entry;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count   <= '0;
            r_head    <= 1'b0;
            r_instret <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_pop) r_head <= ~r_head;
            if (w_accept && w_sel.eop) r_instret <= r_instret + 1'b1;
        end
    end

    assign w_head   = r_mem[r_head];
    assign wb_valid = (r_count != 2'd0);
    assign wb_uuid  = wb_valid ? w_head.uuid  : '0;
    assign wb_wid   = wb_valid ? w_head.wid   : '0;
    assign wb_tmask = wb_valid ? w_head.tmask : '0;
    assign wb_PC    = wb_valid ? w_head.PC    : '0;
    assign wb_rd    = wb_valid ? w_head.rd    : '0;
    assign wb_eop   = wb_valid ? w_head.eop   : 1'b0;
    assign wb_data  = wb_valid ? w_head.data  : '0;
    assign instret  = r_instret;

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Randomized and directed bench for vx_commit_arbiter against a queue-based
// reference model; a 3-bit-counter instance covers instret wraparound.
module tb_vx_commit_arbiter;

    localparam int NU = 5;
    localparam int NT = 4;
    localparam int DW = NT * 32;

    typedef struct packed {
        logic [43:0] uuid;
        logic [1:0]  wid;
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic [5:0]  rd;
        logic        eop;
        logic [127:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [NU-1:0]       cmt_valid, cmt_ready, cmt_wb, cmt_eop;
    logic [NU*44-1:0]    cmt_uuid;
    logic [NU*2-1:0]     cmt_wid;
    logic [NU*NT-1:0]    cmt_tmask;
    logic [NU*32-1:0]    cmt_PC;
    logic [NU*6-1:0]     cmt_rd;
    logic [NU*DW-1:0]    cmt_data;
    logic                wb_valid, wb_ready, wb_eop;
    logic [43:0]         wb_uuid;
    logic [1:0]          wb_wid;
    logic [3:0]          wb_tmask;
    logic [31:0]         wb_PC;
    logic [5:0]          wb_rd;
    logic [DW-1:0]       wb_data;
    logic [63:0]         instret;

    logic [NU-1:0]       s_cmt_ready;
    logic                s_wb_valid, s_wb_eop;
    logic [43:0]         s_wb_uuid;
    logic [1:0]          s_wb_wid;
    logic [3:0]          s_wb_tmask;
    logic [31:0]         s_wb_PC;
    logic [5:0]          s_wb_rd;
    logic [DW-1:0]       s_wb_data;
    logic [2:0]          s_instret;

    logic [43:0]  u_uuid  [NU];
    logic [1:0]   u_wid   [NU];
    logic [3:0]   u_tmask [NU];
    logic [31:0]  u_pc    [NU];
    logic [5:0]   u_rd    [NU];
    logic [127:0] u_data  [NU];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_ptr;
    exp_t m_q[$];
    logic [63:0] m_instret;

    always #5 clk = ~clk;

    always_comb begin
        cmt_uuid = '0; cmt_wid = '0; cmt_tmask = '0; cmt_PC = '0; cmt_rd = '0; cmt_data = '0;
        for (int i = 0; i < NU; i++) begin
            cmt_uuid [i*44 +: 44] = u_uuid[i];
            cmt_wid  [i*2  +: 2]  = u_wid[i];
            cmt_tmask[i*NT +: NT] = u_tmask[i];
            cmt_PC   [i*32 +: 32] = u_pc[i];
            cmt_rd   [i*6  +: 6]  = u_rd[i];
            cmt_data [i*DW +: DW] = u_data[i];
        end
    end

    vx_commit_arbiter u_dut (
        .clk(clk), .reset(reset),
        .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_uuid(cmt_uuid), .cmt_wid(cmt_wid),
        .cmt_tmask(cmt_tmask), .cmt_PC(cmt_PC), .cmt_rd(cmt_rd), .cmt_wb(cmt_wb),
        .cmt_eop(cmt_eop), .cmt_data(cmt_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_uuid(wb_uuid), .wb_wid(wb_wid),
        .wb_tmask(wb_tmask), .wb_PC(wb_PC), .wb_rd(wb_rd), .wb_eop(wb_eop),
        .wb_data(wb_data), .instret(instret)
    );

    vx_commit_arbiter #(.CNT_WIDTH(3)) u_dut_small (
        .clk(clk), .reset(reset),
        .cmt_valid(cmt_valid), .cmt_ready(s_cmt_ready), .cmt_uuid(cmt_uuid), .cmt_wid(cmt_wid),
        .cmt_tmask(cmt_tmask), .cmt_PC(cmt_PC), .cmt_rd(cmt_rd), .cmt_wb(cmt_wb),
        .cmt_eop(cmt_eop), .cmt_data(cmt_data),
        .wb_valid(s_wb_valid), .wb_ready(wb_ready), .wb_uuid(s_wb_uuid), .wb_wid(s_wb_wid),
        .wb_tmask(s_wb_tmask), .wb_PC(s_wb_PC), .wb_rd(s_wb_rd), .wb_eop(s_wb_eop),
        .wb_data(s_wb_data), .instret(s_instret)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_unit(input int i, input logic v, input logic wb, input logic eop);
        cmt_valid[i] = v;
        cmt_wb[i]    = wb;
        cmt_eop[i]   = eop;
        u_uuid[i]    = {$urandom(), $urandom()};
        u_wid[i]     = 2'($urandom());
        u_tmask[i]   = 4'($urandom());
        u_pc[i]      = $urandom();
        u_rd[i]      = 6'($urandom());
        u_data[i]    = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic clear_units();
        for (int i = 0; i < NU; i++) set_unit(i, 1'b0, 1'b0, 1'b0);
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        logic [NU-1:0] exp_ready;
        int   g;
        exp_t head;
        exp_t e;
        #1;
        g = -1;
        for (int k = 0; k < NU; k++) begin
            int c;
            c = (m_ptr + k) % NU;
            if (g < 0 && cmt_valid[c]) g = c;
        end
        exp_ready = '0;
        if (reset && g >= 0 && (!cmt_wb[g] || m_q.size() < 2)) exp_ready[g] = 1'b1;
        head = (m_q.size() > 0) ? m_q[0] : '0;
        check("cmt_ready", 128'(cmt_ready), 128'(exp_ready));
        check("wb_valid", 128'(wb_valid), 128'(m_q.size() > 0));
        check("wb_uuid", 128'(wb_uuid), 128'(head.uuid));
        check("wb_wid", 128'(wb_wid), 128'(head.wid));
        check("wb_tmask", 128'(wb_tmask), 128'(head.tmask));
        check("wb_PC", 128'(wb_PC), 128'(head.pc));
        check("wb_rd", 128'(wb_rd), 128'(head.rd));
        check("wb_eop", 128'(wb_eop), 128'(head.eop));
        check("wb_data", wb_data, head.data);
        check("instret", 128'(instret), 128'(m_instret));
        check("instret_wrap", 128'(s_instret), 128'(m_instret[2:0]));
        @(posedge clk);
        if (!reset) begin
            m_q.delete();
            m_ptr     = 0;
            m_instret = '0;
        end else begin
            if (m_q.size() > 0 && wb_ready) begin
                $display("writeback rd=%0d uuid=%0h eop=%0d", m_q[0].rd, m_q[0].uuid, m_q[0].eop);
                void'(m_q.pop_front());
            end
            if (exp_ready != '0) begin
                if (cmt_wb[g]) begin
                    e = '{uuid: u_uuid[g], wid: u_wid[g], tmask: u_tmask[g], pc: u_pc[g],
                          rd: u_rd[g], eop: cmt_eop[g], data: u_data[g]};
                    m_q.push_back(e);
                end
                if (cmt_eop[g]) m_instret = m_instret + 64'd1;
                m_ptr = (g + 1) % NU;
                $display("commit unit=%0d wb=%0d eop=%0d instret=%0d", g, cmt_wb[g], cmt_eop[g], m_instret);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b0;
        wb_ready = 1'b0;
        cmt_valid = '0; cmt_wb = '0; cmt_eop = '0;
        clear_units();
        repeat (3) @(negedge clk);
        m_ptr = 0; m_instret = '0; m_q.delete();
        step();

        // Unit 0 presented while reset is released.
        set_unit(0, 1'b1, 1'b1, 1'b1);
        u_rd[0] = 6'd5; u_data[0] = 128'h11;
        wb_ready = 1'b1;
        reset    = 1'b1;
        step();
        clear_units();
        step();
        step();

        // All units streaming with writeback ready.
        for (int i = 0; i < NU; i++) set_unit(i, 1'b1, 1'b1, 1'b1);
        repeat (10) step();
        clear_units();
        step(); step();

        // Backpressure with two wb units, then a silent retire while full.
        wb_ready = 1'b0;
        set_unit(0, 1'b1, 1'b1, 1'b1);
        set_unit(1, 1'b1, 1'b1, 1'b1);
        step(); step();
        cmt_valid[0] = 1'b0; cmt_valid[1] = 1'b0;
        step(); step();
        set_unit(2, 1'b1, 1'b0, 1'b1);
        step();
        clear_units();
        step();
        wb_ready = 1'b1;
        repeat (3) step();

        // Multi-packet instruction: eop=0 then eop=1 from one unit.
        set_unit(3, 1'b1, 1'b1, 1'b0);
        step();
        set_unit(3, 1'b1, 1'b1, 1'b1);
        step();
        clear_units();
        repeat (3) step();

        // Reset with two entries pending.
        wb_ready = 1'b0;
        for (int i = 0; i < NU; i++) set_unit(i, 1'b1, 1'b1, 1'b1);
        repeat (3) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        wb_ready = 1'b1;
        repeat (3) step();

        // Randomized traffic with occasional resets and tmask==0 entries.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NU; i++) begin
                set_unit(i, 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 3) != 0),
                         1'($urandom_range(0, 3) != 0));
                if ($urandom_range(0, 7) == 0) u_tmask[i] = '0;
            end
            wb_ready = 1'($urandom_range(0, 99) < 65);
            reset    = ($urandom_range(0, 99) != 0);
            step();
        end
        reset = 1'b1;
        clear_units();
        wb_ready = 1'b1;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
